// File: rtl/fxu_reservation_station_if.sv
// rtl/fxu_reservation_station_if.sv - dispatch, CDB and issue bundle for the FXU reservation station
interface fxu_reservation_station_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 4,
    parameter int OPC_W  = 4,
    parameter int IMM_W  = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic              in_valid;
    logic [TAG_W-1:0]  in_rob_idx;
    logic [OPC_W-1:0]  in_opcode;
    logic [IMM_W-1:0]  in_imm;
    logic              in_a_valid;
    logic [DATA_W-1:0] in_a_value;
    logic [TAG_W-1:0]  in_a_owner;
    logic              in_b_valid;
    logic [DATA_W-1:0] in_b_value;
    logic [TAG_W-1:0]  in_b_owner;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_rob_idx;
    logic [DATA_W-1:0] cdb_value;

    logic              full;
    logic [CW-1:0]     count;

    logic              issue_valid;
    logic              issue_ready;
    logic [TAG_W-1:0]  issue_rob_idx;
    logic [OPC_W-1:0]  issue_opcode;
    logic [IMM_W-1:0]  issue_imm;
    logic [DATA_W-1:0] issue_a;
    logic [DATA_W-1:0] issue_b;

    modport master (
        output in_valid, in_rob_idx, in_opcode, in_imm,
               in_a_valid, in_a_value, in_a_owner,
               in_b_valid, in_b_value, in_b_owner,
               cdb_valid, cdb_rob_idx, cdb_value, issue_ready,
        input  full, count, issue_valid, issue_rob_idx, issue_opcode,
               issue_imm, issue_a, issue_b
    );

    modport slave (
        input  in_valid, in_rob_idx, in_opcode, in_imm,
               in_a_valid, in_a_value, in_a_owner,
               in_b_valid, in_b_value, in_b_owner,
               cdb_valid, cdb_rob_idx, cdb_value, issue_ready,
        output full, count, issue_valid, issue_rob_idx, issue_opcode,
               issue_imm, issue_a, issue_b
    );
endinterface

// File: rtl/fxu_reservation_station.sv
// rtl/fxu_reservation_station.sv - compacting reservation station feeding one fixed-point unit
module fxu_reservation_station #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 4,
    parameter int OPC_W  = 4,
    parameter int IMM_W  = 8
) (
    input logic                     clk,
    input logic                     rst_n,
    input logic                     flush,
    fxu_reservation_station_if.slave rs
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [OPC_W-1:0]  opc;
        logic [IMM_W-1:0]  imm;
        logic              a_rdy;
        logic [DATA_W-1:0] a_val;
        logic [TAG_W-1:0]  a_own;
        logic              b_rdy;
        logic [DATA_W-1:0] b_val;
        logic [TAG_W-1:0]  b_own;
    } ent_t;

    ent_t          ent_q [DEPTH];
    logic [CW-1:0] cnt_q;

    ent_t          woke    [DEPTH];
    ent_t          shifted [DEPTH];
    ent_t          nxt     [DEPTH];
    ent_t          new_ent;
    logic [CW-1:0] cnt_after;
    logic [CW-1:0] cnt_nxt;
    logic          cand_found;
    logic [IW-1:0] cand_idx;
    logic          do_issue;
    logic          do_disp;

    // Scan from the top so the last hit is the oldest ready entry.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (CW'(i) < cnt_q && ent_q[i].a_rdy && ent_q[i].b_rdy) begin
                cand_found = 1'b1;
                cand_idx   = IW'(i);
            end
        end
    end

    assign rs.full        = (cnt_q == CW'(DEPTH));
    assign rs.count       = cnt_q;
    assign rs.issue_valid = cand_found;
    assign rs.issue_rob_idx = cand_found ? ent_q[cand_idx].tag   : '0;
    assign rs.issue_opcode  = cand_found ? ent_q[cand_idx].opc   : '0;
    assign rs.issue_imm     = cand_found ? ent_q[cand_idx].imm   : '0;
    assign rs.issue_a       = cand_found ? ent_q[cand_idx].a_val : '0;
    assign rs.issue_b       = cand_found ? ent_q[cand_idx].b_val : '0;

    assign do_issue = cand_found && rs.issue_ready;
    assign do_disp  = rs.in_valid && !rs.full;

    // Wakeup first, then compaction, so a woken entry keeps its update after shifting.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = ent_q[i];
            if (rs.cdb_valid && !ent_q[i].a_rdy && ent_q[i].a_own == rs.cdb_rob_idx) begin
                woke[i].a_rdy = 1'b1;
                woke[i].a_val = rs.cdb_value;
            end
            if (rs.cdb_valid && !ent_q[i].b_rdy && ent_q[i].b_own == rs.cdb_rob_idx) begin
                woke[i].b_rdy = 1'b1;
                woke[i].b_val = rs.cdb_value;
            end
        end

        for (int i = 0; i < DEPTH - 1; i++) begin
            shifted[i] = (do_issue && IW'(i) >= cand_idx) ? woke[i + 1] : woke[i];
        end
        shifted[DEPTH - 1] = do_issue ? '0 : woke[DEPTH - 1];

        new_ent.tag   = rs.in_rob_idx;
        new_ent.opc   = rs.in_opcode;
        new_ent.imm   = rs.in_imm;
        new_ent.a_own = rs.in_a_owner;
        new_ent.b_own = rs.in_b_owner;
        if (!rs.in_a_valid && rs.cdb_valid && rs.cdb_rob_idx == rs.in_a_owner) begin
            new_ent.a_rdy = 1'b1;
            new_ent.a_val = rs.cdb_value;
        end else begin
            new_ent.a_rdy = rs.in_a_valid;
            new_ent.a_val = rs.in_a_value;
        end
        if (!rs.in_b_valid && rs.cdb_valid && rs.cdb_rob_idx == rs.in_b_owner) begin
            new_ent.b_rdy = 1'b1;
            new_ent.b_val = rs.cdb_value;
        end else begin
            new_ent.b_rdy = rs.in_b_valid;
            new_ent.b_val = rs.in_b_value;
        end

        cnt_after = cnt_q - CW'(do_issue);
        for (int i = 0; i < DEPTH; i++) begin
            nxt[i] = (do_disp && CW'(i) == cnt_after) ? new_ent : shifted[i];
        end
        cnt_nxt = cnt_after + CW'(do_disp);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= nxt[i];
            cnt_q <= cnt_nxt;
        end
    end
endmodule

// File: tb/tb_fxu_reservation_station.sv
// tb/tb_fxu_reservation_station.sv - directed checks for fxu_reservation_station
module tb_fxu_reservation_station;
    logic clk;
    logic rst_n;
    logic flush;
    int   n_cmp;
    int   n_err;

    fxu_reservation_station_if #(.DEPTH(4), .DATA_W(16), .TAG_W(4), .OPC_W(4), .IMM_W(8)) bus ();

    fxu_reservation_station #(.DEPTH(4), .DATA_W(16), .TAG_W(4), .OPC_W(4), .IMM_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .rs    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [3:0] tag, input logic av, input logic [15:0] aval,
                        input logic [3:0] aown, input logic bv, input logic [15:0] bval,
                        input logic [3:0] bown);
        bus.in_valid   = 1'b1;
        bus.in_rob_idx = tag;
        bus.in_opcode  = tag;
        bus.in_imm     = {4'h0, tag};
        bus.in_a_valid = av;
        bus.in_a_value = aval;
        bus.in_a_owner = aown;
        bus.in_b_valid = bv;
        bus.in_b_value = bval;
        bus.in_b_owner = bown;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic cdb(input logic v, input logic [3:0] tag, input logic [15:0] val);
        bus.cdb_valid   = v;
        bus.cdb_rob_idx = tag;
        bus.cdb_value   = val;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.issue_ready = 1'b0;
        idle();
        disp(4'd0, 1'b0, 16'd0, 4'd0, 1'b0, 16'd0, 4'd0);
        idle();
        cdb(1'b0, 4'd0, 16'd0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
        chk("rst_issue_a", 32'(bus.issue_a), 32'd0);
        rst_n = 1'b1;

        // 1: simple ready op
        bus.issue_ready = 1'b1;
        disp(4'd3, 1'b1, 16'd5, 4'd0, 1'b1, 16'd7, 4'd0);
        step();
        idle();
        chk("t1_valid", 32'(bus.issue_valid), 32'd1);
        chk("t1_rob", 32'(bus.issue_rob_idx), 32'd3);
        chk("t1_a", 32'(bus.issue_a), 32'd5);
        chk("t1_b", 32'(bus.issue_b), 32'd7);
        chk("t1_imm", 32'(bus.issue_imm), 32'd3);
        chk("t1_count", 32'(bus.count), 32'd1);
        step();
        chk("t1_count_after", 32'(bus.count), 32'd0);
        chk("t1_valid_after", 32'(bus.issue_valid), 32'd0);

        // 2: younger ready op bypasses older pending op; CDB wakeup
        bus.issue_ready = 1'b0;
        disp(4'd1, 1'b0, 16'd0, 4'd9, 1'b1, 16'd2, 4'd0);
        step();
        disp(4'd2, 1'b1, 16'd10, 4'd0, 1'b1, 16'd11, 4'd0);
        step();
        idle();
        chk("t2_count", 32'(bus.count), 32'd2);
        chk("t2_first_rob", 32'(bus.issue_rob_idx), 32'd2);
        bus.issue_ready = 1'b1;
        step();
        chk("t2_count1", 32'(bus.count), 32'd1);
        chk("t2_pending_valid", 32'(bus.issue_valid), 32'd0);
        cdb(1'b1, 4'd9, 16'h00AA);
        step();
        cdb(1'b0, 4'd0, 16'd0);
        chk("t2_woke_valid", 32'(bus.issue_valid), 32'd1);
        chk("t2_woke_rob", 32'(bus.issue_rob_idx), 32'd1);
        chk("t2_woke_a", 32'(bus.issue_a), 32'h00AA);
        chk("t2_woke_b", 32'(bus.issue_b), 32'd2);
        step();
        chk("t2_count0", 32'(bus.count), 32'd0);

        // 3: capture broadcast in the dispatch cycle
        bus.issue_ready = 1'b0;
        disp(4'd5, 1'b0, 16'd0, 4'd6, 1'b1, 16'd3, 4'd0);
        cdb(1'b1, 4'd6, 16'h1234);
        step();
        idle();
        cdb(1'b0, 4'd0, 16'd0);
        chk("t3_valid", 32'(bus.issue_valid), 32'd1);
        chk("t3_rob", 32'(bus.issue_rob_idx), 32'd5);
        chk("t3_a", 32'(bus.issue_a), 32'h1234);
        bus.issue_ready = 1'b1;
        step();
        chk("t3_count0", 32'(bus.count), 32'd0);

        // 4: fill, drop when full, issue does not free a slot for same-edge dispatch
        bus.issue_ready = 1'b0;
        for (int t = 8; t < 12; t++) begin
            disp(4'(t), 1'b1, 16'(t), 4'd0, 1'b1, 16'd1, 4'd0);
            step();
        end
        chk("t4_full", 32'(bus.full), 32'd1);
        chk("t4_count4", 32'(bus.count), 32'd4);
        disp(4'd12, 1'b1, 16'd12, 4'd0, 1'b1, 16'd1, 4'd0);
        step();
        chk("t4_drop_count", 32'(bus.count), 32'd4);
        chk("t4_head_rob", 32'(bus.issue_rob_idx), 32'd8);
        disp(4'd13, 1'b1, 16'd13, 4'd0, 1'b1, 16'd1, 4'd0);
        bus.issue_ready = 1'b1;
        step();
        idle();
        chk("t4_count3", 32'(bus.count), 32'd3);
        chk("t4_full_drop", 32'(bus.full), 32'd0);
        chk("t4_rob9", 32'(bus.issue_rob_idx), 32'd9);
        chk("t4_a9", 32'(bus.issue_a), 32'd9);
        step();
        chk("t4_rob10", 32'(bus.issue_rob_idx), 32'd10);
        step();
        chk("t4_rob11", 32'(bus.issue_rob_idx), 32'd11);
        step();
        chk("t4_count0", 32'(bus.count), 32'd0);
        chk("t4_empty_valid", 32'(bus.issue_valid), 32'd0);

        // 5: issue and dispatch on the same edge
        bus.issue_ready = 1'b0;
        disp(4'd1, 1'b1, 16'd21, 4'd0, 1'b1, 16'd0, 4'd0);
        step();
        disp(4'd2, 1'b1, 16'd22, 4'd0, 1'b1, 16'd0, 4'd0);
        step();
        disp(4'd3, 1'b1, 16'd23, 4'd0, 1'b1, 16'd0, 4'd0);
        bus.issue_ready = 1'b1;
        step();
        idle();
        chk("t5_count2", 32'(bus.count), 32'd2);
        chk("t5_rob2", 32'(bus.issue_rob_idx), 32'd2);
        step();
        chk("t5_rob3", 32'(bus.issue_rob_idx), 32'd3);
        chk("t5_a3", 32'(bus.issue_a), 32'd23);
        step();
        chk("t5_count0", 32'(bus.count), 32'd0);

        // 5b: issue and wakeup of a shifting entry on the same edge
        bus.issue_ready = 1'b0;
        disp(4'd1, 1'b1, 16'd1, 4'd0, 1'b1, 16'd1, 4'd0);
        step();
        disp(4'd2, 1'b1, 16'd4, 4'd0, 1'b0, 16'd0, 4'd12);
        step();
        idle();
        bus.issue_ready = 1'b1;
        cdb(1'b1, 4'd12, 16'h0055);
        step();
        cdb(1'b0, 4'd0, 16'd0);
        chk("t5b_count1", 32'(bus.count), 32'd1);
        chk("t5b_valid", 32'(bus.issue_valid), 32'd1);
        chk("t5b_rob2", 32'(bus.issue_rob_idx), 32'd2);
        chk("t5b_b", 32'(bus.issue_b), 32'h0055);
        step();
        chk("t5b_count0", 32'(bus.count), 32'd0);

        // 6: flush overrides dispatch; async reset clears mid-stream
        bus.issue_ready = 1'b0;
        for (int t = 1; t < 4; t++) begin
            disp(4'(t), 1'b1, 16'(t), 4'd0, 1'b1, 16'd0, 4'd0);
            step();
        end
        chk("t6_count3", 32'(bus.count), 32'd3);
        disp(4'd4, 1'b1, 16'd4, 4'd0, 1'b1, 16'd0, 4'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        chk("t6_flush_count", 32'(bus.count), 32'd0);
        chk("t6_flush_valid", 32'(bus.issue_valid), 32'd0);
        disp(4'd6, 1'b1, 16'd6, 4'd0, 1'b1, 16'd0, 4'd0);
        step();
        step();
        idle();
        chk("t6_pre_rst_count", 32'(bus.count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_count", 32'(bus.count), 32'd0);
        chk("t6_async_valid", 32'(bus.issue_valid), 32'd0);
        chk("t6_async_rob", 32'(bus.issue_rob_idx), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("t6_post_count", 32'(bus.count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
